// File: rtl/fpu_operand_unpack.sv
// fpu_operand_unpack
// Operand-side front end of the FPU arithmetic path. Accepts two raw binary32
// operands over a valid/ready handshake, decodes each into sign, biased
// exponent, 24-bit significand (hidden bit restored) and class flags, and
// buffers the decoded pair in a small FIFO so that consumer back-pressure
// never creates a combinational ready path.
//
// Ports
//   clk_i          core clock, rising edge
//   reset_i        asynchronous active-low reset
//   flush_i        synchronous flush, drops every buffered entry
//   in_valid_i     operand pair valid          in_ready_o   count != DEPTH
//   op_a_i/op_b_i  raw binary32 operands
//   out_valid_o    head entry valid (count!=0) out_ready_i  consumer takes head
//   sign/exp/sig   decoded fields of the head entry, A and B
//   isNaN/isInf/isZero/isSub  class flags of the head entry, A and B
//   isSignaling_o  A or B of the head entry is a signaling NaN
//
// Occupancy states (held in count, no separate state register)
//   state   | meaning
//   EMPTY   | count == 0, pop impossible, out_valid_o low
//   PARTIAL | 0 < count < DEPTH, push and pop may coincide
//   FULL    | count == DEPTH, push impossible, in_ready_o low

module fpu_operand_unpack #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        sign_A_o,
    output logic        sign_B_o,
    output logic [7:0]  exp_A_o,
    output logic [7:0]  exp_B_o,
    output logic [23:0] sig_A_o,
    output logic [23:0] sig_B_o,
    output logic        isNaNA_o,
    output logic        isNaNB_o,
    output logic        isInfA_o,
    output logic        isInfB_o,
    output logic        isZeroA_o,
    output logic        isZeroB_o,
    output logic        isSubA_o,
    output logic        isSubB_o,
    output logic        isSignaling_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int OPND_W  = 37;               // sign + exp + sig + 4 flags
    localparam int ENTRY_W = 2 * OPND_W + 1;   // A, B, signaling

    // Decoded operand layout: {sign, exp[7:0], sig[23:0], nan, inf, zero, sub}
    function automatic logic [OPND_W-1:0] decode(input logic [31:0] op);
        logic [7:0]  e;
        logic [22:0] f;
        logic        e_max;
        logic        e_min;
        logic        f_nz;
        e     = op[30:23];
        f     = op[22:0];
        e_max = (e == 8'hFF);
        e_min = (e == 8'h00);
        f_nz  = (f != 23'd0);
        return {op[31], e, !e_min, f,
                e_max && f_nz, e_max && !f_nz, e_min && !f_nz, e_min && f_nz};
    endfunction

    // Signaling NaN: NaN whose quiet bit (fraction MSB) is clear.
    function automatic logic is_snan(input logic [31:0] op);
        return (op[30:23] == 8'hFF) && (op[22:0] != 23'd0) && !op[22];
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    assign in_ready_o  = (count != CNT_W'(DEPTH));
    assign out_valid_o = (count != '0);

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    assign entry_in = {decode(op_a_i), decode(op_b_i),
                       is_snan(op_a_i) || is_snan(op_b_i)};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Flush wins over a coincident push or pop; storage keeps stale data.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs always reflect the head slot, valid or not.
    assign head = mem[rd_ptr];

    assign {sign_A_o, exp_A_o, sig_A_o, isNaNA_o, isInfA_o, isZeroA_o, isSubA_o}
        = head[ENTRY_W-1 -: OPND_W];
    assign {sign_B_o, exp_B_o, sig_B_o, isNaNB_o, isInfB_o, isZeroB_o, isSubB_o}
        = head[OPND_W : 1];
    assign isSignaling_o = head[0];

endmodule

// File: tb/tb_fpu_operand_unpack.sv
module tb_fpu_operand_unpack;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        sign_A_o, sign_B_o;
    logic [7:0]  exp_A_o, exp_B_o;
    logic [23:0] sig_A_o, sig_B_o;
    logic        isNaNA_o, isNaNB_o, isInfA_o, isInfB_o;
    logic        isZeroA_o, isZeroB_o, isSubA_o, isSubB_o;
    logic        isSignaling_o;

    always #5 clk_i = ~clk_i;

    fpu_operand_unpack #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sign_A_o(sign_A_o), .sign_B_o(sign_B_o),
        .exp_A_o(exp_A_o), .exp_B_o(exp_B_o),
        .sig_A_o(sig_A_o), .sig_B_o(sig_B_o),
        .isNaNA_o(isNaNA_o), .isNaNB_o(isNaNB_o),
        .isInfA_o(isInfA_o), .isInfB_o(isInfB_o),
        .isZeroA_o(isZeroA_o), .isZeroB_o(isZeroB_o),
        .isSubA_o(isSubA_o), .isSubB_o(isSubB_o),
        .isSignaling_o(isSignaling_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference FIFO of raw operand pairs still held by the design.
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {sign, exp, sig, nan, inf, zero, sub} computed arithmetically from the value.
    function automatic logic [36:0] ref_dec(input logic [31:0] x);
        logic [31:0] s, e, f, sg;
        logic nan, inf, zer, sub;
        s   = x / 32'h8000_0000;
        e   = (x / 32'h0080_0000) % 256;
        f   = x % 32'h0080_0000;
        sg  = f + ((e != 0) ? 32'h0080_0000 : 32'd0);
        nan = (e == 255) && (f != 0);
        inf = (e == 255) && (f == 0);
        zer = (e == 0) && (f == 0);
        sub = (e == 0) && (f != 0);
        return {s[0], e[7:0], sg[23:0], nan, inf, zer, sub};
    endfunction

    function automatic logic ref_snan(input logic [31:0] x);
        logic [31:0] e, f;
        e = (x / 32'h0080_0000) % 256;
        f = x % 32'h0080_0000;
        return (e == 255) && (f != 0) && (f < 32'h0040_0000);
    endfunction

    function automatic logic [74:0] dut_head();
        return {sign_A_o, exp_A_o, sig_A_o, isNaNA_o, isInfA_o, isZeroA_o, isSubA_o,
                sign_B_o, exp_B_o, sig_B_o, isNaNB_o, isInfB_o, isZeroB_o, isSubB_o,
                isSignaling_o};
    endfunction

    task automatic check_model();
        logic [74:0] exp_head;
        chk("out_valid", 80'(out_valid_o), 80'(qa.size() != 0));
        chk("in_ready", 80'(in_ready_o), 80'(qa.size() != DEPTH));
        if (qa.size() > 0) begin
            exp_head = {ref_dec(qa[0]), ref_dec(qb[0]), ref_snan(qa[0]) | ref_snan(qb[0])};
            chk("head", 80'(dut_head()), 80'(exp_head));
        end
    endtask

    // Drive one cycle from the negedge, update the model at the edge, check at next negedge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input logic f);
        logic do_push, do_pop;
        in_valid_i  = v;
        op_a_i      = a;
        op_b_i      = b;
        out_ready_i = r;
        flush_i     = f;
        @(posedge clk_i);
        if (f) begin
            qa.delete();
            qb.delete();
        end else begin
            do_pop  = r && (qa.size() > 0);
            do_push = v && (qa.size() < DEPTH);
            if (do_pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (do_push) begin
                qa.push_back(a);
                qb.push_back(b);
            end
        end
        @(negedge clk_i);
        check_model();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 4))
            0: x[30:23] = 8'hFF;
            1: x[30:23] = 8'h00;
            2: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
            3: begin x[30:23] = 8'h00; x[22:0] = 23'd0; end
            default: ;
        endcase
        return x;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [36:0] ea;
        logic [36:0] eb;
        logic        es;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [74:0] h;
        logic [36:0] ha, hb;
        logic [31:0] first_a;

        vecs[0] = '{32'h3F800000, 32'hC0400000,
                    {1'b0, 8'h7F, 24'h800000, 4'b0000}, {1'b1, 8'h80, 24'hC00000, 4'b0000}, 1'b0};
        vecs[1] = '{32'h7F800001, 32'h7FC00000,
                    {1'b0, 8'hFF, 24'h800001, 4'b1000}, {1'b0, 8'hFF, 24'hC00000, 4'b1000}, 1'b1};
        vecs[2] = '{32'h7F800000, 32'h7FC00000,
                    {1'b0, 8'hFF, 24'h800000, 4'b0100}, {1'b0, 8'hFF, 24'hC00000, 4'b1000}, 1'b0};
        vecs[3] = '{32'h00000001, 32'h80000000,
                    {1'b0, 8'h00, 24'h000001, 4'b0001}, {1'b1, 8'h00, 24'h000000, 4'b0010}, 1'b0};
        vecs[4] = '{32'h7FBFFFFF, 32'h00000000,
                    {1'b0, 8'hFF, 24'hBFFFFF, 4'b1000}, {1'b0, 8'h00, 24'h000000, 4'b0010}, 1'b1};
        vecs[5] = '{32'hFF800000, 32'h807FFFFF,
                    {1'b1, 8'hFF, 24'h800000, 4'b0100}, {1'b1, 8'h00, 24'h7FFFFF, 4'b0001}, 1'b0};

        reset_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        op_a_i = '0; op_b_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_valid", 80'(out_valid_o), 80'(0));
        chk("reset_ready", 80'(in_ready_o), 80'(1));
        chk("reset_data", 80'(dut_head()), 80'(0));
        reset_i = 1'b1;

        // Table-driven decode: push into empty FIFO, inspect head, pop it.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            h  = dut_head();
            ha = h[74:38];
            hb = h[37:1];
            chk($sformatf("vec%0d_valid", i), 80'(out_valid_o), 80'(1));
            chk($sformatf("vec%0d_A", i), 80'(ha), 80'(vecs[i].ea));
            chk($sformatf("vec%0d_B", i), 80'(hb), 80'(vecs[i].eb));
            chk($sformatf("vec%0d_snan", i), 80'(h[0]), 80'(vecs[i].es));
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        end

        // Back-pressure: fill, extra push ignored, head stable, drain in order.
        first_a = rand_op();
        cycle(1'b1, first_a, rand_op(), 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        chk("bp_full_ready", 80'(in_ready_o), 80'(0));
        cycle(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        h  = dut_head();
        ha = h[74:38];
        chk("bp_head_stable", 80'(ha), 80'(ref_dec(first_a)));
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("bp_ready_after_pop", 80'(in_ready_o), 80'(1));
        while (qa.size() > 0) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Sustained push+pop at count 1 across pointer wrap.
        cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);
            chk("pp_valid", 80'(out_valid_o), 80'(1));
            chk("pp_ready", 80'(in_ready_o), 80'(1));
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with coincident push at count 2.
        cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
        cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b1);
        chk("flush_valid", 80'(out_valid_o), 80'(0));
        chk("flush_ready", 80'(in_ready_o), 80'(1));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_op(), rand_op(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset mid-stream, with a push offered during reset.
        cycle(1'b1, 32'h3F800000, 32'hFFFFFFFF, 1'b0, 1'b0);
        #2;
        reset_i    = 1'b0;
        in_valid_i = 1'b1;
        #1;
        chk("async_rst_valid", 80'(out_valid_o), 80'(0));
        chk("async_rst_ready", 80'(in_ready_o), 80'(1));
        chk("async_rst_data", 80'(dut_head()), 80'(0));
        qa.delete();
        qb.delete();
        @(negedge clk_i);
        reset_i = 1'b1;
        check_model();
        cycle(1'b1, 32'h40490FDB, 32'h7F800002, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_operand_unpack.md
# fpu_operand_unpack

Operand-side front end of the FPU arithmetic path: accepts two raw IEEE-754 binary32 operands over a valid/ready handshake and decodes them into sign, exponent, 24-bit significand (hidden bit restored) and class flags. These are the unpacked fields and NaN/signaling indications consumed by the FPU sub-modules (min/max, compare, add, mul). A small decoded-result FIFO decouples the issuing stage from the consuming sub-module so back-pressure never creates a combinational ready path.

## Interface
- DEPTH, 2, FIFO entries of decoded operand pairs; legal values 2 or 4.
- clk_i  in  1  core clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; drops all buffered entries.
- in_valid_i  in  1  operand pair on op_a_i/op_b_i is valid.
- in_ready_o  out  1  FIFO can accept a pair; registered, equals (count != DEPTH).
- op_a_i, op_b_i  in  32  raw binary32 operands A and B.
- out_valid_o  out  1  head entry valid; equals (count != 0).
- out_ready_i  in  1  consumer takes head entry.
- sign_A_o, sign_B_o  out  1  sign bits.
- exp_A_o, exp_B_o  out  8  biased exponents, unmodified.
- sig_A_o, sig_B_o  out  24  {hidden, fraction}; hidden = (exp != 0).
- isNaNA_o, isNaNB_o  out  1  exp == 8'hFF and fraction != 0.
- isInfA_o, isInfB_o  out  1  exp == 8'hFF and fraction == 0.
- isZeroA_o, isZeroB_o  out  1  exp == 0 and fraction == 0.
- isSubA_o, isSubB_o  out  1  exp == 0 and fraction != 0.
- isSignaling_o  out  1  A or B is a signaling NaN (NaN with fraction[22] == 0).

## Operation
- Push: in_valid_i && in_ready_o at a rising edge; both operands decoded combinationally and written as one entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid_o && out_ready_i at a rising edge; rd_ptr increments modulo DEPTH.
- count tracks occupancy 0..DEPTH; states EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- Simultaneous push and pop: count unchanged, both pointers advance; legal in PARTIAL, and in EMPTY push only (no pop possible), in FULL pop only (in_ready_o low).
- All output data ports are driven from the head entry (rd_ptr); held stable while out_valid_o && !out_ready_i.
- When out_valid_o is low, data outputs show the stale head slot; consumers ignore them.
- flush_i: count, wr_ptr, rd_ptr cleared to 0 at next edge; flush takes priority over a simultaneous push or pop (both discarded).
- Decoding is purely bitwise; no normalization of subnormals, no NaN canonicalization (done downstream).
- isSignaling_o is an OR over both operands; qNaN (fraction[22] == 1) never sets it.

## Timing
- Reset (reset_i low, asynchronous): count = 0, wr_ptr = rd_ptr = 0, out_valid_o = 0, in_ready_o = 1, all storage and data outputs = 0.
- Reset release mid-transfer: any in-flight handshake in the reset cycle is lost; first push possible at first rising edge with reset_i high.
- Latency: entry pushed at edge N is visible with out_valid_o = 1 after edge N (1 cycle); no bypass.
- Throughput: one pair per cycle sustained when consumer holds out_ready_i high.
- in_ready_o and out_valid_o depend only on registered count; no combinational path from out_ready_i or in_valid_i to any output.
- Wrap-around: pointers wrap from DEPTH-1 to 0 without gap; order strictly FIFO.

## Test plan
- Normal decode: push A = 0x3F800000, B = 0xC0400000 -> after 1 edge out_valid_o = 1, sign_A 0/exp_A 0x7F/sig_A 0x800000, sign_B 1/exp_B 0x80/sig_B 0xC00000, all class flags 0.
- Special classes: A = 0x7F800001, B = 0x7FC00000 -> isNaNA = isNaNB = 1, isSignaling_o = 1; repeat with A = 0x7F800000 -> isInfA = 1, isNaNA = 0, isSignaling_o = 0.
- Subnormal/zero: A = 0x00000001, B = 0x80000000 -> isSubA = 1, sig_A = 0x000001, exp_A = 0; isZeroB = 1, sign_B = 1, sig_B = 0.
- Back-pressure: out_ready_i = 0, push DEPTH pairs -> in_ready_o = 0 after DEPTH-th edge, head data unchanged; extra in_valid_i ignored; raise out_ready_i -> entries drain in push order, in_ready_o = 1 after first pop.
- Simultaneous push/pop at count 1 across pointer wrap for 3*DEPTH cycles -> count stays 1, outputs match inputs delayed 1 cycle.
- Flush and reset: with count = 2, assert flush_i together with push -> next cycle out_valid_o = 0, in_ready_o = 1; assert reset_i low mid-stream -> outputs 0 immediately without clock edge.
